master_full_adder: RTL and testbench
====================================

// Module: master_full_adder
// PURPOSE
//  WIDTH-bit ripple-carry adder built from a generate chain of 1-bit full-adder cells.
//  Computes {COUT,SUM} = A + B + CIN.
//  Results are registered on clk, so the block drops into pipelined datapaths as a one-stage adder.
//  Also flags two's-complement overflow for signed users.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits (>=1)
// PORTS
//  clk    input   1      rising-edge clock; the only clock
//  rst_n  input   1      asynchronous, active-low reset
//  A      input   WIDTH  operand A (unsigned or two's complement)
//  B      input   WIDTH  operand B
//  CIN    input   1      carry in to bit 0
//  SUM    output  WIDTH  registered sum bits
//  COUT   output  1      registered carry out of MSB
//  OVF    output  1      registered signed overflow; may be left unconnected
// BEHAVIOUR
//  - Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
//    - rst_n=0 immediately forces SUM=0, COUT=0, OVF=0, independent of clk.
//    - Registers hold 0 while rst_n is low.
//  - Ripple chain, per bit i:
//    - s[i] = A[i]^B[i]^c[i]
//    - c[i+1] = A[i]&B[i] | c[i]&(A[i]^B[i])
//    - c[0] = CIN
//    - Internal carry vector c[WIDTH:0]; c[1..WIDTH-1] are internal only.
//  - Each rising clk edge with rst_n=1 registers:
//    - SUM <= s
//    - COUT <= c[WIDTH]
//    - OVF <= c[WIDTH]^c[WIDTH-1]
//  - Latency: exactly 1 cycle.
//    - Operands sampled at edge N appear on the outputs after edge N.
//    - A new result every cycle, no stall or handshake.
//  - Wrap-around: the sum is modulo 2^WIDTH; the lost bit appears only on COUT.
//    - 0xFF+0x00+1 -> SUM=0x00, COUT=1.
//  - Maximum case 0xFF+0xFF+1 -> SUM=0xFF, COUT=1, OVF=0.
//  - Reset release:
//    - Outputs stay 0 until the first rising edge with rst_n=1.
//    - That edge captures the operands present at it.
//  - Reset mid-stream: outputs clear asynchronously; in-flight results are discarded.
//  - X/Z on the inputs propagate; no input sanitising.
//  - No combinational path from inputs to outputs.
// TESTING
//  1. rst_n=0 with A=0x00, B=0xAA, CIN=0 -> SUM=0x00, COUT=0, OVF=0 throughout reset.
//  2. Release reset; A=0x00, B=0xAA, CIN=0 -> one edge later SUM=0xAA, COUT=0, OVF=0.
//  3. A=0x56, B=0xAA, CIN=0 -> SUM=0x00, COUT=1, OVF=0.
//     A=0xFF, B=0xAA, CIN=1 -> SUM=0xAA, COUT=1.
//  4. A=0x7F, B=0x01, CIN=0 -> SUM=0x80, COUT=0, OVF=1.
//     A=0x80, B=0x80, CIN=0 -> SUM=0x00, COUT=1, OVF=1.
//  5. Sweep A=0x00..0xFE each cycle, B=0xAA, CIN=A[0].
//     -> Each cycle, {COUT,SUM} equals the A+B+CIN of the previous cycle.
//     -> Zero mismatches.
//  6. Assert rst_n low between clock edges during the sweep.
//     -> Outputs go to 0 immediately, with no clock edge.
//     -> After release, the first result reflects the operands at the first post-release edge.

Source files
------------

// File: rtl/master_full_adder_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// The master side drives the operands and carry in; the slave side (the adder)
// returns the registered sum, carry out and signed overflow flag.
interface master_full_adder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
    logic [WIDTH-1:0] SUM;
    logic             COUT;
    logic             OVF;

    modport master (
        output A,
        output B,
        output CIN,
        input  SUM,
        input  COUT,
        input  OVF
    );

    modport slave (
        input  A,
        input  B,
        input  CIN,
        output SUM,
        output COUT,
        output OVF
    );
endinterface

// File: rtl/master_full_adder.sv
// One-stage pipelined WIDTH-bit ripple-carry adder.
// A chain of 1-bit full-adder cells forms {carry, sum} = A + B + CIN
// combinationally; the sum, the carry out of the MSB and the two's-complement
// overflow flag are then registered, giving exactly one cycle of latency and
// no combinational path from the operands to the outputs.

// Single-bit full adder used as the link of the ripple chain.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic half_sum;

    assign half_sum = a ^ b;
    assign s        = half_sum ^ cin;
    assign cout     = (a & b) | (cin & half_sum);
endmodule

module master_full_adder #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    master_full_adder_if.slave  bus
);
    // carry[i] enters bit i; carry[WIDTH] leaves the MSB.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    assign carry[0] = bus.CIN;

    // Ripple chain: each cell consumes the carry of the bit below it.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
            full_adder_cell u_cell (
                .a    (bus.A[i]),
                .b    (bus.B[i]),
                .cin  (carry[i]),
                .s    (sum_comb[i]),
                .cout (carry[i+1])
            );
        end
    endgenerate

    // Result register: cleared asynchronously by reset, otherwise captures the
    // chain output every cycle. Signed overflow is the disagreement between the
    // carry into and the carry out of the sign bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sum_q  <= sum_comb;
            cout_q <= carry[WIDTH];
            ovf_q  <= carry[WIDTH] ^ carry[WIDTH-1];
        end
    end

    assign bus.SUM  = sum_q;
    assign bus.COUT = cout_q;
    assign bus.OVF  = ovf_q;
endmodule

// File: tb/tb_master_full_adder.sv
// Self-checking bench for master_full_adder (WIDTH = 8).
// Expected results come from plain integer arithmetic on the operands.
module tb_master_full_adder;
    logic clk = 1'b0;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    master_full_adder_if #(.WIDTH(8)) bus_if ();

    master_full_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // Reference: returns {COUT, OVF, SUM} for A + B + CIN.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic cin);
        int unsigned u;
        int          s;
        logic        ovf;
        u   = int'(a) + int'(b) + int'(cin);
        s   = int'($signed(a)) + int'($signed(b)) + int'(cin);
        ovf = (s > 127) || (s < -128);
        return {(u > 255), ovf, u[7:0]};
    endfunction

    function automatic logic [9:0] observed();
        return {bus_if.COUT, bus_if.OVF, bus_if.SUM};
    endfunction

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin);
        bus_if.A   = a;
        bus_if.B   = b;
        bus_if.CIN = cin;
    endtask

    // Outputs stay zero throughout reset, across clock edges.
    task automatic test_reset();
        rst_n = 1'b0;
        drive(8'h00, 8'hAA, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (observed() !== 10'h000) begin
                errors++;
                $display("[TB] FAIL reset_hold: got {COUT,OVF,SUM}=%h, expected 000", observed());
            end
        end
    endtask

    // Outputs remain zero until the first edge after release, which then
    // captures the operands present at it.
    task automatic test_release();
        rst_n = 1'b1;
        #2;
        checks++;
        if (observed() !== 10'h000) begin
            errors++;
            $display("[TB] FAIL release_pre_edge: got %h, expected 000", observed());
        end
        @(negedge clk);
        checks++;
        if (observed() !== {1'b0, 1'b0, 8'hAA}) begin
            errors++;
            $display("[TB] FAIL release_first: got %h, expected 0aa", observed());
        end
    endtask

    // Hand-computed corner cases: wrap-around, overflow both ways, maximum.
    task automatic test_directed();
        logic [7:0] va [6] = '{8'h56, 8'hFF, 8'h7F, 8'h80, 8'hFF, 8'hFF};
        logic [7:0] vb [6] = '{8'hAA, 8'hAA, 8'h01, 8'h80, 8'h00, 8'hFF};
        logic       vc [6] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
        logic [9:0] ve [6] = '{{1'b1, 1'b0, 8'h00},
                               {1'b1, 1'b0, 8'hAA},
                               {1'b0, 1'b1, 8'h80},
                               {1'b1, 1'b1, 8'h00},
                               {1'b1, 1'b0, 8'h00},
                               {1'b1, 1'b0, 8'hFF}};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(va[i], vb[i], vc[i]);
            @(negedge clk);
            checks++;
            if (observed() !== ve[i]) begin
                errors++;
                $display("[TB] FAIL directed_%0d: A=%h B=%h CIN=%b got %h, expected %h",
                         i, va[i], vb[i], vc[i], observed(), ve[i]);
            end
        end
    endtask

    // Back-to-back sweep: every cycle's output is the previous cycle's sum.
    task automatic test_sweep();
        logic [7:0] a;
        logic [9:0] exp_q;
        @(negedge clk);
        a = 8'h00;
        drive(a, 8'hAA, a[0]);
        exp_q = model(a, 8'hAA, a[0]);
        for (int i = 1; i <= 8'hFE; i++) begin
            @(negedge clk);
            checks++;
            if (observed() !== exp_q) begin
                errors++;
                $display("[TB] FAIL sweep: A=%h got %h, expected %h", a, observed(), exp_q);
            end
            a = 8'(i);
            drive(a, 8'hAA, a[0]);
            exp_q = model(a, 8'hAA, a[0]);
        end
        @(negedge clk);
        checks++;
        if (observed() !== exp_q) begin
            errors++;
            $display("[TB] FAIL sweep_last: got %h, expected %h", observed(), exp_q);
        end
    endtask

    // Reset asserted between edges mid-sweep clears outputs at once and
    // discards the in-flight result.
    task automatic test_async_reset();
        logic [7:0] a;
        logic [9:0] exp_q;
        @(negedge clk);
        a = 8'h10;
        drive(a, 8'hAA, a[0]);
        exp_q = model(a, 8'hAA, a[0]);
        for (int i = 8'h11; i < 8'h20; i++) begin
            @(negedge clk);
            checks++;
            if (observed() !== exp_q) begin
                errors++;
                $display("[TB] FAIL pre_reset_sweep: got %h, expected %h", observed(), exp_q);
            end
            a = 8'(i);
            drive(a, 8'hAA, a[0]);
            exp_q = model(a, 8'hAA, a[0]);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (observed() !== 10'h000) begin
            errors++;
            $display("[TB] FAIL async_clear: got %h, expected 000", observed());
        end
        @(posedge clk);
        #1;
        checks++;
        if (observed() !== 10'h000) begin
            errors++;
            $display("[TB] FAIL reset_edge_hold: got %h, expected 000", observed());
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'h33, 8'h55, 1'b1);
        #2;
        checks++;
        if (observed() !== 10'h000) begin
            errors++;
            $display("[TB] FAIL post_release_pre_edge: got %h, expected 000", observed());
        end
        @(negedge clk);
        checks++;
        if (observed() !== {1'b0, 1'b1, 8'h89}) begin
            errors++;
            $display("[TB] FAIL post_release_first: got %h, expected 189", observed());
        end
    endtask

    // Random operands every cycle, expectations queued one cycle ahead.
    task automatic test_random();
        logic [9:0] pending [$];
        logic [9:0] exp_v;
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (pending.size() > 0) begin
                exp_v = pending.pop_front();
                checks++;
                if (observed() !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL random_%0d: got %h, expected %h", i, observed(), exp_v);
                end
            end
            a = 8'($urandom);
            b = 8'($urandom);
            c = 1'($urandom);
            drive(a, b, c);
            pending.push_back(model(a, b, c));
        end
        @(negedge clk);
        exp_v = pending.pop_front();
        checks++;
        if (observed() !== exp_v) begin
            errors++;
            $display("[TB] FAIL random_last: got %h, expected %h", observed(), exp_v);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] start");
        test_reset();
        test_release();
        test_directed();
        test_sweep();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
